// File: rtl/dma_addr_sequencer.sv
// DMA transfer-side address sequencer: presents the upper/lower address bytes for
// one service cycle, steps the address and word count, and handles terminal count.
module dma_addr_sequencer #(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              progWe,
  input  logic [CH_W-1:0]   progCh,
  input  logic              progSel,
  input  logic [ADDR_W-1:0] progData,
  input  logic              xferStart,
  input  logic [CH_W-1:0]   xferCh,
  input  logic              addrDec,
  input  logic              autoInit,
  input  logic              holdAddr,
  input  logic              statusRd,
  output logic              aen,
  output logic              adstb,
  output logic [7:0]        dbOut,
  output logic              dbOe,
  output logic [7:0]        addrOut,
  output logic              addrValid,
  output logic              tc,
  output logic              done,
  output logic              busy,
  output logic [NUM_CH-1:0] maskSetReq,
  output logic [NUM_CH-1:0] tcStatus
);

  typedef enum logic [1:0] {S_IDLE, S_UPPER, S_LOWER, S_UPDATE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                dec_q, dec_d;
  logic                auto_q, auto_d;
  logic                hold_q, hold_d;
  logic                last_vld_q, last_vld_d;
  logic [CH_W-1:0]     last_ch_q, last_ch_d;
  logic [ADDR_W-1:0]   base_addr_q [NUM_CH];
  logic [ADDR_W-1:0]   base_addr_d [NUM_CH];
  logic [ADDR_W-1:0]   curr_addr_q [NUM_CH];
  logic [ADDR_W-1:0]   curr_addr_d [NUM_CH];
  logic [ADDR_W-1:0]   base_word_q [NUM_CH];
  logic [ADDR_W-1:0]   base_word_d [NUM_CH];
  logic [ADDR_W-1:0]   curr_word_q [NUM_CH];
  logic [ADDR_W-1:0]   curr_word_d [NUM_CH];
  logic [NUM_CH-1:0]   upper_vld_q, upper_vld_d;

  logic                aen_q, aen_d;
  logic                adstb_q, adstb_d;
  logic [7:0]          db_out_q, db_out_d;
  logic                db_oe_q, db_oe_d;
  logic [7:0]          addr_out_q, addr_out_d;
  logic                addr_vld_q, addr_vld_d;
  logic                tc_q, tc_d;
  logic                done_q, done_d;
  logic [NUM_CH-1:0]   mask_req_q, mask_req_d;
  logic [NUM_CH-1:0]   tc_status_q, tc_status_d;

  // Registered outputs are computed one edge ahead, so they must see a program
  // write landing on the same edge as the channel's register value.
  logic [CH_W-1:0]     tgt_ch;
  logic                prog_tgt;
  logic [ADDR_W-1:0]   addr_view;
  logic [ADDR_W-1:0]   word_view;
  logic                uv_view;
  logic [ADDR_W-1:0]   step_addr;
  logic [ADDR_W-1:0]   step_word;

  assign tgt_ch    = (state_q == S_IDLE) ? xferCh : ch_q;
  assign prog_tgt  = progWe && (progCh == tgt_ch);
  assign addr_view = (prog_tgt && !progSel) ? progData : curr_addr_q[tgt_ch];
  assign word_view = (prog_tgt && progSel)  ? progData : curr_word_q[tgt_ch];
  assign uv_view   = upper_vld_q[tgt_ch] && !prog_tgt;
  assign step_addr = hold_q ? curr_addr_q[ch_q] :
                     dec_q  ? curr_addr_q[ch_q] - ONE : curr_addr_q[ch_q] + ONE;
  assign step_word = curr_word_q[ch_q] - ONE;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dec_d       = dec_q;
    auto_d      = auto_q;
    hold_d      = hold_q;
    last_vld_d  = last_vld_q;
    last_ch_d   = last_ch_q;
    base_addr_d = base_addr_q;
    curr_addr_d = curr_addr_q;
    base_word_d = base_word_q;
    curr_word_d = curr_word_q;
    upper_vld_d = upper_vld_q;
    aen_d       = 1'b0;
    adstb_d     = 1'b0;
    db_out_d    = '0;
    db_oe_d     = 1'b0;
    addr_out_d  = '0;
    addr_vld_d  = 1'b0;
    tc_d        = 1'b0;
    done_d      = 1'b0;
    mask_req_d  = '0;
    tc_status_d = statusRd ? '0 : tc_status_q;

    case (state_q)
      S_IDLE: begin
        if (xferStart) begin
          ch_d   = xferCh;
          dec_d  = addrDec;
          auto_d = autoInit;
          hold_d = holdAddr;
          aen_d  = 1'b1;
          if (uv_view && last_vld_q && (last_ch_q == xferCh)) begin
            state_d    = S_LOWER;
            addr_out_d = addr_view[7:0];
            addr_vld_d = 1'b1;
          end else begin
            state_d  = S_UPPER;
            db_out_d = addr_view[ADDR_W-1:8];
            db_oe_d  = 1'b1;
            adstb_d  = 1'b1;
          end
        end
      end
      S_UPPER: begin
        state_d           = S_LOWER;
        aen_d             = 1'b1;
        addr_out_d        = addr_view[7:0];
        addr_vld_d        = 1'b1;
        upper_vld_d[ch_q] = 1'b1;
      end
      S_LOWER: begin
        state_d = S_UPDATE;
        aen_d   = 1'b1;
        done_d  = 1'b1;
        tc_d    = (word_view == '0);
        if (word_view == '0) begin
          tc_status_d[ch_q] = 1'b1;
          mask_req_d[ch_q]  = !auto_q;
        end
      end
      S_UPDATE: begin
        state_d    = S_IDLE;
        last_vld_d = 1'b1;
        last_ch_d  = ch_q;
        if (tc_q && auto_q) begin
          curr_addr_d[ch_q] = base_addr_q[ch_q];
          curr_word_d[ch_q] = base_word_q[ch_q];
          upper_vld_d[ch_q] = 1'b0;
        end else begin
          curr_addr_d[ch_q] = step_addr;
          curr_word_d[ch_q] = step_word;
          if (step_addr[ADDR_W-1:8] != curr_addr_q[ch_q][ADDR_W-1:8])
            upper_vld_d[ch_q] = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A program write overrides any step or reload of the same register.
    if (progWe) begin
      if (!progSel) begin
        base_addr_d[progCh] = progData;
        curr_addr_d[progCh] = progData;
      end else begin
        base_word_d[progCh] = progData;
        curr_word_d[progCh] = progData;
      end
      upper_vld_d[progCh] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      dec_q       <= 1'b0;
      auto_q      <= 1'b0;
      hold_q      <= 1'b0;
      last_vld_q  <= 1'b0;
      last_ch_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= '0;
        curr_addr_q[i] <= '0;
        base_word_q[i] <= '0;
        curr_word_q[i] <= '0;
      end
      upper_vld_q <= '0;
      aen_q       <= 1'b0;
      adstb_q     <= 1'b0;
      db_out_q    <= '0;
      db_oe_q     <= 1'b0;
      addr_out_q  <= '0;
      addr_vld_q  <= 1'b0;
      tc_q        <= 1'b0;
      done_q      <= 1'b0;
      mask_req_q  <= '0;
      tc_status_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dec_q       <= dec_d;
      auto_q      <= auto_d;
      hold_q      <= hold_d;
      last_vld_q  <= last_vld_d;
      last_ch_q   <= last_ch_d;
      base_addr_q <= base_addr_d;
      curr_addr_q <= curr_addr_d;
      base_word_q <= base_word_d;
      curr_word_q <= curr_word_d;
      upper_vld_q <= upper_vld_d;
      aen_q       <= aen_d;
      adstb_q     <= adstb_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      addr_out_q  <= addr_out_d;
      addr_vld_q  <= addr_vld_d;
      tc_q        <= tc_d;
      done_q      <= done_d;
      mask_req_q  <= mask_req_d;
      tc_status_q <= tc_status_d;
    end
  end

  assign aen        = aen_q;
  assign adstb      = adstb_q;
  assign dbOut      = db_out_q;
  assign dbOe       = db_oe_q;
  assign addrOut    = addr_out_q;
  assign addrValid  = addr_vld_q;
  assign tc         = tc_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign maskSetReq = mask_req_q;
  assign tcStatus   = tc_status_q;

endmodule
